// File: rtl/risc16_mem_responder.sv
// Single-ported 16-bit memory behind a valid/ready request/response pair with a fixed wait-state count.
// Optional feature: define RISC16_MEM_RANGE_ERR_EN to flag (and suppress) accesses whose upper address bits are set.
module risc16_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. Once a side
  // raises valid its payload stays stable until the transfer edge.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  logic [15:0] mem [DEPTH];

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        lat_we_q;
  logic [15:0] lat_addr_q;
  logic [15:0] lat_wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic                  accept;
  logic                  enter_resp;
  logic                  rsp_done;
  logic                  cmt_we;
  logic [15:0]           cmt_addr;
  logic [15:0]           cmt_wdata;
  logic [DEPTH_LOG2-1:0] cmt_idx;
  logic                  cmt_oob;

  // The committing transaction comes straight from the request port when a
  // zero-wait accept jumps directly into RESP, otherwise from the latched copy.
  always_comb begin
    accept     = req_valid && (state_q == ST_IDLE);
    enter_resp = (accept && ZERO_WAIT) ||
                 ((state_q == ST_WAIT) && (cnt_q <= 4'd1));
    rsp_done   = (state_q == ST_RESP) && rsp_ready;
    if (state_q == ST_IDLE) begin
      cmt_we    = req_we;
      cmt_addr  = req_addr;
      cmt_wdata = req_wdata;
    end else begin
      cmt_we    = lat_we_q;
      cmt_addr  = lat_addr_q;
      cmt_wdata = lat_wdata_q;
    end
    cmt_idx = cmt_addr[DEPTH_LOG2-1:0];
  end

`ifdef RISC16_MEM_RANGE_ERR_EN
  localparam logic [15:0] UPPER_MASK = ~16'((32'd1 << DEPTH_LOG2) - 32'd1);
  assign cmt_oob = |(cmt_addr & UPPER_MASK);
`else
  // Upper address bits wrap silently; fold them so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmt_addr;
  assign cmt_oob          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ZERO_WAIT ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 16'h0000;
      lat_wdata_q <= 16'h0000;
      rdata_q     <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        lat_we_q    <= req_we;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        cnt_q       <= WAIT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end

      // Response payload is captured on the same edge the write commits.
      if (enter_resp) begin
        err_q <= cmt_oob;
        if (cmt_oob) begin
          rdata_q <= 16'h0000;
        end else if (cmt_we) begin
          rdata_q <= cmt_wdata;
        end else begin
          rdata_q <= mem[cmt_idx];
        end
      end else if (rsp_done) begin
        rdata_q     <= 16'h0000;
        err_q       <= 1'b0;
        lat_we_q    <= 1'b0;
        lat_addr_q  <= 16'h0000;
        lat_wdata_q <= 16'h0000;
      end
    end
  end

  // Storage is deliberately not reset; a reset edge never commits a write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cmt_we && !cmt_oob) begin
      mem[cmt_idx] <= cmt_wdata;
    end
  end

  assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : 16'h0000;
  assign rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_risc16_mem_responder.sv
// Bench for risc16_mem_responder: a WAIT_CYCLES=2 instance for most scenarios and a
// WAIT_CYCLES=0 instance for back-to-back throughput, both against a simple memory model.
module tb_risc16_mem_responder;

  localparam int DL = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  dbg_state;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [15:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [1:0]  z_dbg_state;

  risc16_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  risc16_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] model_mem [256];
  int          wr_idx_q[$];
  logic [15:0] exp_q[$];
  logic        exp_err_q[$];

  function automatic bit addr_oob(input logic [15:0] a);
`ifdef RISC16_MEM_RANGE_ERR_EN
    return a[15:8] != 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  // Applies one transaction to the model and queues the response it must produce.
  task automatic model_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int idx;
    idx = int'(addr[7:0]);
    if (addr_oob(addr)) begin
      exp_q.push_back(16'h0000);
      exp_err_q.push_back(1'b1);
    end else if (we) begin
      model_mem[idx] = wdata;
      wr_idx_q.push_back(idx);
      exp_q.push_back(wdata);
      exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(model_mem[idx]);
      exp_err_q.push_back(1'b0);
    end
  endtask

  // ---------------- driver tasks (all start and end just after a falling edge) ----------------
  task automatic drive_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output bit ok);
    int t;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = rsp_valid;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int stall, output logic [15:0] d, output logic [15:0] d_late,
                         output logic e, output int lat, output bit acc_ok, output bit rsp_ok);
    drive_req(we, addr, wdata, acc_ok);
    wait_rsp(lat, rsp_ok);
    d = rsp_rdata;
    e = rsp_err;
    repeat (stall) @(negedge clk);
    d_late = rsp_rdata;
    if (rsp_ok) release_rsp();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 16'h0; z_req_wdata = 16'h0; z_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b rdata=%h err=%b, expected 0/0000/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b, expected 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] d, dl, ed;
    logic e, ee;
    int lat;
    bit a, r;
    model_txn(1'b1, 16'h0005, 16'hBEEF);
    run_txn(1'b1, 16'h0005, 16'hBEEF, 0, d, dl, e, lat, a, r);
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    n_checks++;
    if (!(a && r)) begin n_errors++; $display("FAIL wr_handshake: accept=%0d rsp=%0d, expected 1/1", a, r); end
    n_checks++;
    if (lat !== 3) begin n_errors++; $display("FAIL wr_latency: got %0d cycles, expected 3", lat); end
    n_checks++;
    if (d !== ed || e !== ee) begin n_errors++; $display("FAIL wr_echo: rdata=%h err=%b, expected %h/%b", d, e, ed, ee); end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL after_rsp_idle: valid=%b rdata=%h ready=%b, expected 0/0000/1", rsp_valid, rsp_rdata, req_ready);
    end
    model_txn(1'b0, 16'h0005, 16'h0000);
    run_txn(1'b0, 16'h0005, 16'h0000, 0, d, dl, e, lat, a, r);
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    n_checks++;
    if (d !== ed || d !== 16'hBEEF || lat !== 3) begin
      n_errors++;
      $display("FAIL raw_read: rdata=%h lat=%0d, expected %h/3", d, lat, ed);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0, ed, wd;
    int lat;
    bit a, r;
    model_txn(1'b0, 16'h0005, 16'h0000);
    drive_req(1'b0, 16'h0005, 16'h0000, a);
    wait_rsp(lat, r);
    d0 = rsp_rdata;
    ed = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++;
    if (d0 !== ed || !r) begin n_errors++; $display("FAIL bp_data: rdata=%h valid=%b, expected %h/1", d0, r, ed); end
    // A new request held high while busy must be ignored until IDLE.
    wd = 16'($urandom);
    req_we = 1'b1; req_addr = 16'h0040; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_stable[%0d]: valid=%b rdata=%h ready=%b, expected 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, d0);
      end
      @(negedge clk);
    end
    release_rsp();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release: ready=%b valid=%b, expected 1/0", req_ready, rsp_valid);
    end
    model_txn(1'b1, 16'h0040, wd);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat, r);
    ed = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++;
    if (!r || lat !== 3 || rsp_rdata !== ed) begin
      n_errors++;
      $display("FAIL held_req_accept: valid=%b lat=%0d rdata=%h, expected 1/3/%h", r, lat, rsp_rdata, ed);
    end
    if (r) release_rsp();
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] d, dl, ed;
    logic e;
    int lat;
    bit a, r, seen;
    model_txn(1'b1, 16'h0010, 16'h0000);
    run_txn(1'b1, 16'h0010, 16'h0000, 0, d, dl, e, lat, a, r);
    void'(exp_q.pop_front());
    void'(exp_err_q.pop_front());
    drive_req(1'b1, 16'h0010, 16'h1234, a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_wait: rsp_seen=%b ready=%b, expected 0/1", seen, req_ready);
    end
    model_txn(1'b0, 16'h0010, 16'h0000);
    run_txn(1'b0, 16'h0010, 16'h0000, 0, d, dl, e, lat, a, r);
    ed = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++;
    if (d !== ed || d !== 16'h0000) begin
      n_errors++;
      $display("FAIL rst_no_commit: rdata=%h, expected %h", d, ed);
    end
  endtask

  task automatic test_range();
    logic [15:0] d, dl, ed;
    logic e, ee;
    int lat;
    bit a, r;
    model_txn(1'b1, 16'h0003, 16'h5555);
    run_txn(1'b1, 16'h0003, 16'h5555, 0, d, dl, e, lat, a, r);
    void'(exp_q.pop_front());
    void'(exp_err_q.pop_front());
    model_txn(1'b1, 16'h0103, 16'hAAAA);
    run_txn(1'b1, 16'h0103, 16'hAAAA, 0, d, dl, e, lat, a, r);
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    n_checks++;
    if (d !== ed || e !== ee || lat !== 3) begin
      n_errors++;
      $display("FAIL range_write: rdata=%h err=%b lat=%0d, expected %h/%b/3", d, e, lat, ed, ee);
    end
    model_txn(1'b0, 16'h0003, 16'h0000);
    run_txn(1'b0, 16'h0003, 16'h0000, 0, d, dl, e, lat, a, r);
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    n_checks++;
    if (d !== ed || e !== ee) begin
      n_errors++;
      $display("FAIL range_readback: rdata=%h err=%b, expected %h/%b", d, e, ed, ee);
    end
  endtask

  task automatic test_random();
    logic [15:0] d, dl, ed, addr, wd;
    logic e, ee, we;
    int lat, stall;
    bit a, r;
    for (int n = 0; n < 30; n++) begin
      we = ($urandom_range(0, 1) == 1) || (wr_idx_q.size() == 0);
      if (we) addr = 16'($urandom_range(0, 255));
      else    addr = 16'(wr_idx_q[$urandom_range(0, wr_idx_q.size() - 1)]);
      if ($urandom_range(0, 3) == 0) addr[15:8] = 8'($urandom_range(1, 255));
      wd = 16'($urandom);
      stall = $urandom_range(0, 3);
      model_txn(we, addr, wd);
      run_txn(we, addr, wd, stall, d, dl, e, lat, a, r);
      ed = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      n_checks++;
      if (!(a && r) || lat !== 3) begin
        n_errors++;
        $display("FAIL rnd_timing[%0d]: accept=%0d rsp=%0d lat=%0d, expected 1/1/3", n, a, r, lat);
      end
      n_checks++;
      if (d !== ed || dl !== ed || e !== ee) begin
        n_errors++;
        $display("FAIL rnd_data[%0d] we=%b addr=%h: rdata=%h/%h err=%b, expected %h err=%b", n, we, addr, d, dl, e, ed, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] zdata [4];
    logic [15:0] zexp_q[$];
    logic [15:0] ze;
    int cyc, last_acc, k, nrsp;
    for (int i = 0; i < 4; i++) zdata[i] = 16'($urandom);
    @(negedge clk);
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1;
    z_req_we    = 1'b1;
    z_req_addr  = 16'h0020;
    z_req_wdata = zdata[0];
    cyc = 0; last_acc = -10; k = 0; nrsp = 0;
    while (nrsp < 8 && cyc < 60) begin
      if (z_rsp_valid) begin
        ze = zexp_q.pop_front();
        n_checks++;
        if (z_rsp_rdata !== ze || (cyc - last_acc) !== 1) begin
          n_errors++;
          $display("FAIL b2b_rsp[%0d]: rdata=%h gap=%0d, expected %h/1", nrsp, z_rsp_rdata, cyc - last_acc, ze);
        end
        nrsp++;
      end
      if (z_req_ready && k < 8) begin
        if (k > 0) begin
          n_checks++;
          if ((cyc - last_acc) !== 2) begin
            n_errors++;
            $display("FAIL b2b_accept_gap[%0d]: got %0d cycles, expected 2", k, cyc - last_acc);
          end
        end
        last_acc = cyc;
        zexp_q.push_back(zdata[k % 4]);
        k++;
        @(posedge clk);
        #1;
        if (k < 8) begin
          z_req_we    = (k < 4);
          z_req_addr  = 16'h0020 + 16'(k % 4);
          z_req_wdata = (k < 4) ? zdata[k] : 16'($urandom);
        end else begin
          z_req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    n_checks++;
    if (nrsp !== 8) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d responses, expected 8", nrsp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid_wait();
    test_range();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/risc16_mem_responder.md
RISC16_MEM_RESPONDER -- requirements
Module: risc16_mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, word-address bits implemented (memory = 2^DEPTH_LOG2 x 16-bit words).
REQ-002 Parameter: WAIT_CYCLES, default 2, wait states between request accept and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  processor presents a memory request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read; sampled at accept.
REQ-008 req_addr  input  16  word address; sampled at accept.
REQ-009 req_wdata  input  16  write data; sampled at accept.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  processor consumes response.
REQ-012 rsp_rdata  output  16  read data (reads) or echoed write data (writes).
REQ-013 rsp_err  output  1  address-range error flag (see Configuration).

Function
REQ-014 FSM states IDLE, WAIT, RESP; exactly one active.
REQ-015 IDLE: req_ready=1, rsp_valid=0; accept occurs on edge where req_valid&&req_ready.
REQ-016 At accept: latch we/addr/wdata; load wait counter with WAIT_CYCLES; go WAIT, or RESP directly if WAIT_CYCLES=0.
REQ-017 WAIT: req_ready=0; counter decrements each cycle; leave for RESP on the edge where counter equals 1.
REQ-018 Latency: rsp_valid first high in cycle WAIT_CYCLES+1 after accept edge (WAIT_CYCLES=0 -> next cycle).
REQ-019 Write commits to memory on the edge entering RESP, never earlier; read data captured on the same edge.
REQ-020 Read-after-write to same address in consecutive transactions returns the new value.
REQ-021 RESP: rsp_valid=1, req_ready=0; rsp_rdata and rsp_err held stable until rsp_valid&&rsp_ready.
REQ-022 On rsp_valid&&rsp_ready: go IDLE; new request accepted no earlier than the following cycle (max one transaction per WAIT_CYCLES+2 cycles).
REQ-023 Requests presented while not IDLE are ignored, not queued; req_valid may stay high and is accepted on return to IDLE.
REQ-024 rsp_rdata outside RESP: 16'h0000.
REQ-025 Addresses use low DEPTH_LOG2 bits for indexing; upper bits handled per Configuration.

Reset
REQ-026 rst asserted: FSM -> IDLE immediately (asynchronous); counter = 0; latched request cleared.
REQ-027 Reset outputs: req_ready=1 after release, rsp_valid=0, rsp_rdata=16'h0000, rsp_err=0.
REQ-028 Memory array not reset; contents preserved across reset.
REQ-029 Reset during WAIT drops the pending transaction; a pending write is never committed.

Configuration
REQ-030 Macro RISC16_MEM_RANGE_ERR_EN.
REQ-031 Defined: any req_addr bit above DEPTH_LOG2-1 set -> write suppressed, rsp_rdata=16'h0000, rsp_err=1 for that response; latency unchanged.
REQ-032 Undefined: upper address bits ignored (addresses wrap modulo 2^DEPTH_LOG2); rsp_err tied to 0.

Verification
REQ-033 WAIT_CYCLES=2: write 16'hBEEF to addr 16'h0005, rsp_ready=1 -> rsp_valid high exactly 3 cycles after accept, rsp_rdata=16'hBEEF; then read 16'h0005 -> 16'hBEEF.
REQ-034 Backpressure: read with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable 4 cycles, req_ready=0 throughout; release -> IDLE next cycle.
REQ-035 WAIT_CYCLES=0: back-to-back reads with req_valid held high -> one accept every 2 cycles, rsp_valid the cycle after each accept.
REQ-036 Reset mid-WAIT: write 16'h1234 to 16'h0010 (old 16'h0000), assert rst one cycle after accept -> rsp_valid never asserted; later read of 16'h0010 returns 16'h0000.
REQ-037 DEPTH_LOG2=8, write 16'hAAAA to 16'h0103: macro defined -> rsp_err=1, read of 16'h0003 unchanged; macro undefined -> rsp_err=0, read of 16'h0003 returns 16'hAAAA.
